dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - the processor memory stage, which has priority;
  - a host/loader port used for program load, result readback and test inspection.
- Sits between the processor's dmem interface and the dmem syncram, which is clocked on ~clock.
- Arbitrates every cycle, stalls the processor when it loses, and bounds host starvation with a streak counter.
- Returns read data through registered response paths tagged by owner.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner tags mark which requester a registered response belongs to.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;
    localparam int STREAK_W    = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PROC = 2'd1,
        OWN_HOST = 2'd2
    } own_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Processor, host and dmem signal bundle around the arbiter.
// slave is the arbiter's view; master is the requester/memory view.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic              proc_req;
    logic              proc_wren;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_stall;
    logic [DATA_W-1:0] proc_rdata;
    logic              proc_rvalid;

    logic              host_req;
    logic              host_wren;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  proc_req, proc_wren, proc_addr, proc_wdata,
        output proc_stall, proc_rdata, proc_rvalid,
        input  host_req, host_wren, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output proc_req, proc_wren, proc_addr, proc_wdata,
        input  proc_stall, proc_rdata, proc_rvalid,
        output host_req, host_wren, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection: processor first, host forced
// once the contended streak reaches MAX_WAIT.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                proc_req,
    input  logic                host_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                win_proc,
    output logic                win_host
);

    localparam logic [STREAK_W-1:0] MW = STREAK_W'(MAX_WAIT);

    always_comb begin
        win_proc = 1'b0;
        win_host = 1'b0;
        unique case (1'b1)
            (proc_req && !host_req): win_proc = 1'b1;
            (!proc_req && host_req): win_host = 1'b1;
            (proc_req && host_req && streak <  MW): win_proc = 1'b1;
            (proc_req && host_req && streak >= MW): win_host = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the MEM stage and the host port,
// with bounded host starvation and owner-tagged read responses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [STREAK_W-1:0] MW = STREAK_W'(MAX_WAIT);

    logic [STREAK_W-1:0] streak;
    logic                win_proc;
    logic                win_host;

    logic [ADDR_W-1:0]   addr_mux;
    logic [DATA_W-1:0]   data_mux;
    logic                wren_mux;
    logic                stall;
    logic                gnt;

    own_e                resp_own;
    logic                resp_rd;
    logic [DATA_W-1:0]   proc_rd_q;
    logic [DATA_W-1:0]   host_rd_q;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .proc_req (bus.proc_req),
        .host_req (bus.host_req),
        .streak   (streak),
        .win_proc (win_proc),
        .win_host (win_host)
    );

    // Nothing reaches dmem or the handshakes while in reset.
    always_comb begin
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
        stall    = 1'b0;
        gnt      = 1'b0;
        if (reset) begin
            unique case (1'b1)
                win_proc: begin
                    addr_mux = bus.proc_addr;
                    data_mux = bus.proc_wdata;
                    wren_mux = bus.proc_wren;
                end
                win_host: begin
                    addr_mux = bus.host_addr;
                    data_mux = bus.host_wdata;
                    wren_mux = bus.host_wren;
                end
                default: ;
            endcase
            stall = bus.proc_req & ~win_proc;
            gnt   = win_host;
        end
    end

    assign bus.mem_address = addr_mux;
    assign bus.mem_data    = data_mux;
    assign bus.mem_wren    = wren_mux;
    assign bus.proc_stall  = stall;
    assign bus.host_gnt    = gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (!bus.host_req || win_host) begin
            streak <= '0;
        end else if (win_proc && streak < MW) begin
            streak <= streak + 1'b1;
        end
    end

    // mem_q is valid at the edge closing the issue cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_own  <= OWN_NONE;
            resp_rd   <= 1'b0;
            proc_rd_q <= '0;
            host_rd_q <= '0;
        end else begin
            resp_own <= OWN_NONE;
            resp_rd  <= 1'b0;
            if (win_proc) begin
                resp_own <= OWN_PROC;
                resp_rd  <= ~bus.proc_wren;
                if (!bus.proc_wren) proc_rd_q <= bus.mem_q;
            end else if (win_host) begin
                resp_own <= OWN_HOST;
                resp_rd  <= ~bus.host_wren;
                if (!bus.host_wren) host_rd_q <= bus.mem_q;
            end
        end
    end

    assign bus.proc_rdata  = proc_rd_q;
    assign bus.host_rdata  = host_rd_q;
    assign bus.proc_rvalid = resp_rd && (resp_own == OWN_PROC);
    assign bus.host_rvalid = resp_rd && (resp_own == OWN_HOST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-clocked dmem model.
// Also sweeps the standalone winner picker.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [31:0] mem [0:4095];

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic       pk_p;
    logic       pk_h;
    logic [3:0] pk_s;
    logic       pk_wp;
    logic       pk_wh;

    dmem_arb_pick #(.MAX_WAIT(4)) u_pick (
        .proc_req (pk_p),
        .host_req (pk_h),
        .streak   (pk_s),
        .win_proc (pk_wp),
        .win_host (pk_wh)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // syncram clocked on the inverted clock
    always @(negedge clock) begin
        if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setp(input logic r, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
        bus.proc_req   = r;
        bus.proc_wren  = w;
        bus.proc_addr  = a;
        bus.proc_wdata = d;
    endtask

    task automatic seth(input logic r, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
        bus.host_req   = r;
        bus.host_wren  = w;
        bus.host_addr  = a;
        bus.host_wdata = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        setp(1'b1, 1'b1, 12'h010, 32'h0);
        seth(1'b1, 1'b1, 12'h020, 32'h0);
        pk_p = 1'b0;
        pk_h = 1'b0;
        pk_s = 4'd0;

        // picker sweep over streak 0..MAX_WAIT
        for (int p = 0; p < 2; p++) begin
            for (int h = 0; h < 2; h++) begin
                for (int s = 0; s <= 4; s++) begin
                    pk_p = p[0];
                    pk_h = h[0];
                    pk_s = 4'(s);
                    #1;
                    chk($sformatf("pick_p p%0d h%0d s%0d", p, h, s),
                        {31'd0, pk_wp},
                        {31'd0, (p == 1) && ((h == 0) || (s < 4))});
                    chk($sformatf("pick_h p%0d h%0d s%0d", p, h, s),
                        {31'd0, pk_wh},
                        {31'd0, (h == 1) && ((p == 0) || (s == 4))});
                end
            end
        end

        // reset state, requests present but blocked
        chk("rst_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("rst_gnt", {31'd0, bus.host_gnt}, 32'd0);
        chk("rst_stall", {31'd0, bus.proc_stall}, 32'd0);
        chk("rst_prdata", bus.proc_rdata, 32'd0);
        chk("rst_hrdata", bus.host_rdata, 32'd0);
        chk("rst_prvalid", {31'd0, bus.proc_rvalid}, 32'd0);
        chk("rst_hrvalid", {31'd0, bus.host_rvalid}, 32'd0);
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("idle_addr", {20'd0, bus.mem_address}, 32'd0);
        chk("idle_wren", {31'd0, bus.mem_wren}, 32'd0);
        tick();

        // 1: processor only
        setp(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        #1;
        chk("t1_wren", {31'd0, bus.mem_wren}, 32'd1);
        chk("t1_addr", {20'd0, bus.mem_address}, 32'h010);
        chk("t1_data", bus.mem_data, 32'hDEADBEEF);
        chk("t1_stall0", {31'd0, bus.proc_stall}, 32'd0);
        tick();
        setp(1'b1, 1'b0, 12'h010, 32'h0);
        #1;
        chk("t1_stall1", {31'd0, bus.proc_stall}, 32'd0);
        chk("t1_wr_norv", {31'd0, bus.proc_rvalid}, 32'd0);
        tick();
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("t1_rvalid", {31'd0, bus.proc_rvalid}, 32'd1);
        chk("t1_rdata", bus.proc_rdata, 32'hDEADBEEF);
        chk("t1_hrv", {31'd0, bus.host_rvalid}, 32'd0);
        tick();
        #1;
        chk("t1_pulse", {31'd0, bus.proc_rvalid}, 32'd0);

        // 2: host only
        seth(1'b1, 1'b1, 12'h3FF, 32'h12345678);
        #1;
        chk("t2_gnt0", {31'd0, bus.host_gnt}, 32'd1);
        chk("t2_wren", {31'd0, bus.mem_wren}, 32'd1);
        chk("t2_addr", {20'd0, bus.mem_address}, 32'h3FF);
        tick();
        seth(1'b1, 1'b0, 12'h3FF, 32'h0);
        #1;
        chk("t2_gnt1", {31'd0, bus.host_gnt}, 32'd1);
        chk("t2_wr_norv", {31'd0, bus.host_rvalid}, 32'd0);
        tick();
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("t2_rvalid", {31'd0, bus.host_rvalid}, 32'd1);
        chk("t2_rdata", bus.host_rdata, 32'h12345678);
        chk("t2_prv", {31'd0, bus.proc_rvalid}, 32'd0);
        chk("t2_prdata", bus.proc_rdata, 32'hDEADBEEF);
        tick();

        // 3: sustained contention
        for (int i = 0; i < 10; i++) begin
            setp(1'b1, 1'b0, 12'h010, 32'h0);
            seth(1'b1, 1'b0, 12'h3FF, 32'h0);
            #1;
            chk($sformatf("t3_gnt c%0d", i), {31'd0, bus.host_gnt},
                {31'd0, (i == 4) || (i == 9)});
            chk($sformatf("t3_stall c%0d", i), {31'd0, bus.proc_stall},
                {31'd0, (i == 4) || (i == 9)});
            tick();
        end
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("t3_streak", {28'd0, dut.streak}, 32'd0);
        chk("t3_hrv", {31'd0, bus.host_rvalid}, 32'd1);
        tick();

        // 4: alternating reads after seeding two words
        setp(1'b1, 1'b1, 12'h001, 32'h0000000A);
        tick();
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        seth(1'b1, 1'b1, 12'h002, 32'h0000000B);
        #1;
        chk("t4_seed_gnt", {31'd0, bus.host_gnt}, 32'd1);
        tick();
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        setp(1'b1, 1'b0, 12'h001, 32'h0);
        tick();
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        seth(1'b1, 1'b0, 12'h002, 32'h0);
        #1;
        chk("t4_prv", {31'd0, bus.proc_rvalid}, 32'd1);
        chk("t4_prdata", bus.proc_rdata, 32'h0000000A);
        chk("t4_hrv0", {31'd0, bus.host_rvalid}, 32'd0);
        chk("t4_hkeep", bus.host_rdata, 32'h12345678);
        tick();
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("t4_hrv", {31'd0, bus.host_rvalid}, 32'd1);
        chk("t4_hrdata", bus.host_rdata, 32'h0000000B);
        chk("t4_prv0", {31'd0, bus.proc_rvalid}, 32'd0);
        chk("t4_pkeep", bus.proc_rdata, 32'h0000000A);
        tick();

        // 5: reset asserted while a proc read response is pending
        setp(1'b1, 1'b0, 12'h010, 32'h0);
        tick();
        reset = 1'b0;
        setp(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        seth(1'b1, 1'b1, 12'h020, 32'h0);
        #1;
        chk("t5_prv", {31'd0, bus.proc_rvalid}, 32'd0);
        chk("t5_prdata", bus.proc_rdata, 32'd0);
        chk("t5_hrdata", bus.host_rdata, 32'd0);
        chk("t5_streak", {28'd0, dut.streak}, 32'd0);
        chk("t5_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("t5_gnt", {31'd0, bus.host_gnt}, 32'd0);
        tick();
        #1;
        chk("t5_wren2", {31'd0, bus.mem_wren}, 32'd0);
        chk("t5_prv2", {31'd0, bus.proc_rvalid}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rel_stall", {31'd0, bus.proc_stall}, 32'd0);
        chk("t5_rel_wren", {31'd0, bus.mem_wren}, 32'd1);
        chk("t5_rel_gnt", {31'd0, bus.host_gnt}, 32'd0);
        tick();

        // 6: streak clears when the host drops its request
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            setp(1'b1, 1'b0, 12'h010, 32'h0);
            seth(1'b1, 1'b0, 12'h3FF, 32'h0);
            #1;
            chk($sformatf("t6_pre_gnt c%0d", i), {31'd0, bus.host_gnt},
                32'd0);
            tick();
        end
        chk("t6_streak3", {28'd0, dut.streak}, 32'd3);
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("t6_drop_stall", {31'd0, bus.proc_stall}, 32'd0);
        tick();
        chk("t6_streak0", {28'd0, dut.streak}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            seth(1'b1, 1'b0, 12'h3FF, 32'h0);
            #1;
            chk($sformatf("t6_gnt c%0d", i), {31'd0, bus.host_gnt},
                {31'd0, i == 4});
            chk($sformatf("t6_stall c%0d", i), {31'd0, bus.proc_stall},
                {31'd0, i == 4});
            tick();
        end
        setp(1'b0, 1'b0, 12'h0, 32'h0);
        seth(1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        chk("t6_end_streak", {28'd0, dut.streak}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
